ddr4_amm_burst_reader: RTL
==========================

Name: ddr4_amm_burst_reader

Overview:
- Avalon-MM read initiator for the DDR4 EMIF user port (ctrl_amm_0); fetches feature-map/weight tiles for the CNN datapath.
- Accepts one command (start word address, length in 512-bit beats) and splits it into bursts of up to MAX_BURST beats.
- Streams read data out through a ready/valid interface backed by an internal FIFO.
- Only issues a burst when the FIFO has guaranteed room for every beat of it, so the EMIF is never back-pressured.

Parameters:
ADDR_W, 26, Avalon word address width (512-bit word granularity)
DATA_W, 512, data width
BURST_W, 7, burstcount width
MAX_BURST, 64, largest burst issued; must be ≤ 2^(BURST_W-1)
FIFO_DEPTH, 128, read-data FIFO entries; power of 2, ≥ MAX_BURST
LEN_W, 16, command length width (beats)

Ports:
emif_usr_clk  in  1  single clock (EMIF user clock domain)
emif_usr_rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only
cmd_addr  in  ADDR_W  start word address
cmd_len  in  LEN_W  number of beats
amm_ready  in  1  EMIF waitrequest_n
amm_read  out  1  read request
amm_address  out  ADDR_W  burst start address
amm_burstcount  out  BURST_W  beats in burst
amm_readdata  in  DATA_W  read data
amm_readdatavalid  in  1  read data valid
st_valid  out  1  output beat valid
st_ready  in  1  downstream accept
st_data  out  DATA_W  output beat
st_last  out  1  final beat of command
busy  out  1  command in progress
done  out  1  one-cycle pulse when final beat is consumed

Behaviour:
- Reset (async, active-high) values: cmd_ready=1, amm_read=0, amm_address=0, amm_burstcount=0, st_valid=0, st_last=0, busy=0, done=0. FIFO is emptied and all counters are cleared.
- Reset mid-command aborts the command. Beats arriving after reset release are discarded because outstanding=0 and the block is in IDLE.
- State machine:
  - IDLE: on cmd_valid, latch addr/len into remaining, set busy=1.
    - len==0: go to FIN.
    - otherwise: go to ISSUE.
  - ISSUE: compute n = min(remaining, MAX_BURST).
    - When credit ≥ n, assert amm_read with address=next_addr and burstcount=n.
    - credit = FIFO_DEPTH − fifo_count − outstanding, evaluated combinationally from registered counts.
    - While amm_read=1 and amm_ready=0, hold amm_read, amm_address and amm_burstcount stable.
    - Acceptance occurs when amm_read && amm_ready. On acceptance: outstanding += n, next_addr += n, remaining −= n.
    - After acceptance, deassert amm_read for at least one cycle (registered request).
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until outstanding==0 and the final beat is popped (st_valid && st_ready && st_last), then go to FIN.
  - FIN: done=1 for one cycle, busy=0, then go to IDLE.
- Latency:
  - cmd accept at cycle t → first amm_read at t+1 (if credit allows).
  - amm_readdatavalid at cycle r → st_valid at r+1 (registered FIFO output).
- Read data:
  - Each amm_readdatavalid writes one FIFO entry and decrements outstanding.
  - A simultaneous acceptance and readdatavalid nets outstanding += n−1.
  - The FIFO can never overflow by construction. An overflow attempt is a design error, flagged by an assertion.
- st_last is asserted on the beat whose pop count equals the latched len.
- Pop happens on st_valid && st_ready. Simultaneous push and pop on a full or empty FIFO is legal; fifo_count stays unchanged.
- Address arithmetic wraps modulo 2^ADDR_W with no error. Bursts are not split on any boundary.
- amm_read is never asserted outside ISSUE.

Optional Feature:
- Macro: DDR4_RD_PERF_CNT_EN.
- When defined, adds two outputs, each a 32-bit saturating counter cleared on reset and on command acceptance:
  - perf_wait_cyc: counts cycles with amm_read=1 and amm_ready=0.
  - perf_credit_stall: counts ISSUE cycles blocked because credit < n.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. cmd_addr=0x100, cmd_len=150, amm_ready=1, st_ready=1 → three bursts: (0x100,64), (0x140,64), (0x180,22). Exactly 150 st beats; st_last on beat 150; done pulses once; busy falls the same cycle as done.
2. Same command with amm_ready low for 5 cycles at the first request → amm_address and amm_burstcount stable throughout; single acceptance; perf_wait_cyc=5 when DDR4_RD_PERF_CNT_EN is defined.
3. cmd_len=300 with st_ready=0 → after two bursts (128 beats outstanding/in FIFO) no further amm_read. Raise st_ready → issuing resumes; all 300 beats delivered in order with no overflow.
4. cmd_len=0 → cmd_ready drops, done pulses within 2 cycles, no amm_read, no st_valid.
5. Assert emif_usr_rst while 40 beats are outstanding, then feed the 40 late readdatavalid beats → all outputs at reset values; st_valid stays 0; next command (addr 0x0, len 8) completes normally.
6. cmd_addr=0x3FFFFF8 (top of the 26-bit space), len=16 → single burst (0x3FFFFF8,16) issued; next_addr wraps to 0x0000008 internally; 16 beats delivered.

Source files
------------

// File: rtl/ddr4_amm_burst_reader.sv
// ---------------------------------------------------------------------------
// ddr4_amm_burst_reader
//
// Avalon-MM read initiator for the DDR4 EMIF user port. Takes one command
// (start word address + length in 512-bit beats), splits it into bursts of
// at most MAX_BURST beats and streams the returned data out through a
// ready/valid port backed by an internal FIFO. A burst is only requested when
// the FIFO is guaranteed to have room for every beat of it, so readdatavalid
// is never back-pressured.
//
// Optional build macro: DDR4_RD_PERF_CNT_EN adds perf_wait_cyc and
// perf_credit_stall (32-bit saturating, cleared on reset and on command
// acceptance). Without it those ports and counters do not exist.
//
// Ports:
//   emif_usr_clk, emif_usr_rst      clock, async active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_addr, cmd_len               start word address, length in beats
//   amm_ready                       EMIF waitrequest_n
//   amm_read, amm_address,
//   amm_burstcount                  burst request (held while !amm_ready)
//   amm_readdata, amm_readdatavalid returned read beats
//   st_valid/st_ready, st_data,
//   st_last                         output beat stream, last beat of command
//   busy                            command in progress
//   done                            one-cycle pulse after the final beat
//   perf_wait_cyc, perf_credit_stall  (DDR4_RD_PERF_CNT_EN only)
//   dbg_state                       current FSM state for checkers
//
// Handshakes: a transfer happens on any cycle where valid (cmd_valid,
// amm_read, st_valid) and ready (cmd_ready, amm_ready, st_ready) are both
// high; a valid side never drops or changes its payload until accepted.
// ---------------------------------------------------------------------------
module ddr4_amm_burst_reader #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 512,
    parameter int BURST_W    = 7,
    parameter int MAX_BURST  = 64,
    parameter int FIFO_DEPTH = 128,
    parameter int LEN_W      = 16
) (
    input  logic              emif_usr_clk,
    input  logic              emif_usr_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              amm_ready,
    output logic              amm_read,
    output logic [ADDR_W-1:0] amm_address,
    output logic [BURST_W-1:0] amm_burstcount,
    input  logic [DATA_W-1:0] amm_readdata,
    input  logic              amm_readdatavalid,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [DATA_W-1:0] st_data,
    output logic              st_last,
    output logic              busy,
    output logic              done,
`ifdef DDR4_RD_PERF_CNT_EN
    output logic [31:0]       perf_wait_cyc,
    output logic [31:0]       perf_credit_stall,
`endif
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   pop_cnt;
    logic [LEN_W-1:0]   n_src;
    logic [ADDR_W-1:0]  next_addr;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   outstanding;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [BURST_W-1:0] burst_n;
    logic [CNT_W:0]     room_need;
    logic               credit_ok;
    logic               cmd_fire;
    logic               amm_fire;
    logic               push;
    logic               pop;
    logic               final_pop;

    assign dbg_state = state;

    // ---------------- handshake / datapath helpers ----------------
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign amm_fire  = amm_read && amm_ready;
    // Beats arriving with nothing outstanding belong to a command that was
    // aborted by reset; they are dropped.
    assign push      = amm_readdatavalid && (outstanding != '0);
    assign st_valid  = (fifo_count != '0);
    assign st_data   = mem[rd_ptr];
    assign pop       = st_valid && st_ready;
    assign st_last   = st_valid && ((pop_cnt + LEN_W'(1)) == len_q);
    assign final_pop = pop && st_last;

    // In IDLE the burst size comes straight from the incoming command so the
    // first request can go out the cycle after acceptance.
    assign n_src   = (state == S_IDLE) ? cmd_len : remaining;
    assign burst_n = (n_src > LEN_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                 : n_src[BURST_W-1:0];

    // credit = FIFO_DEPTH - fifo_count - outstanding; credit >= n rewritten
    // as a sum so no signed arithmetic is needed.
    assign room_need = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(outstanding)
                     + (CNT_W+1)'(burst_n);
    assign credit_ok = (room_need <= (CNT_W+1)'(FIFO_DEPTH));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) state <= S_IDLE;
        else              state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) state_nxt = (cmd_len == '0) ? S_FIN : S_ISSUE;
            end
            S_ISSUE: begin
                if (amm_fire && (remaining == LEN_W'(amm_burstcount)))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if ((outstanding == '0) && final_pop) state_nxt = S_FIN;
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:  cmd_ready = 1'b1;
            S_ISSUE: busy      = 1'b1;
            S_DRAIN: busy      = 1'b1;
            S_FIN:   done      = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // ---------------- request generation ----------------
    // amm_read is registered: after an acceptance it is low for at least one
    // cycle, which lets outstanding settle before credit is evaluated again.
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            amm_read       <= 1'b0;
            amm_address    <= '0;
            amm_burstcount <= '0;
            remaining      <= '0;
            next_addr      <= '0;
            len_q          <= '0;
        end else if (cmd_fire) begin
            remaining <= cmd_len;
            next_addr <= cmd_addr;
            len_q     <= cmd_len;
            if ((cmd_len != '0) && credit_ok) begin
                amm_read       <= 1'b1;
                amm_address    <= cmd_addr;
                amm_burstcount <= burst_n;
            end
        end else if (state == S_ISSUE) begin
            if (amm_read) begin
                if (amm_ready) begin
                    amm_read  <= 1'b0;
                    next_addr <= next_addr + ADDR_W'(amm_burstcount);
                    remaining <= remaining - LEN_W'(amm_burstcount);
                end
            end else if ((remaining != '0) && credit_ok) begin
                amm_read       <= 1'b1;
                amm_address    <= next_addr;
                amm_burstcount <= burst_n;
            end
        end
    end

    // ---------------- outstanding / FIFO bookkeeping ----------------
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pop_cnt     <= '0;
        end else begin
            outstanding <= outstanding
                         + (amm_fire ? CNT_W'(amm_burstcount) : CNT_W'(0))
                         - (push ? CNT_W'(1) : CNT_W'(0));
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (cmd_fire) pop_cnt <= '0;
            else if (pop) pop_cnt <= pop_cnt + LEN_W'(1);
        end
    end

    // Storage is not reset; only the pointers and count define contents.
    always_ff @(posedge emif_usr_clk) begin
        if (push) mem[wr_ptr] <= amm_readdata;
    end

    // Credit gating makes overflow impossible; reaching it is a design bug.
    fifo_no_overflow: assert property (@(posedge emif_usr_clk)
        disable iff (emif_usr_rst)
        !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

`ifdef DDR4_RD_PERF_CNT_EN
    // ---------------- performance counters ----------------
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            perf_wait_cyc     <= '0;
            perf_credit_stall <= '0;
        end else if (cmd_fire) begin
            perf_wait_cyc     <= '0;
            perf_credit_stall <= '0;
        end else begin
            if (amm_read && !amm_ready && (perf_wait_cyc != '1))
                perf_wait_cyc <= perf_wait_cyc + 32'd1;
            if ((state == S_ISSUE) && !amm_read && (remaining != '0) &&
                !credit_ok && (perf_credit_stall != '1))
                perf_credit_stall <= perf_credit_stall + 32'd1;
        end
    end
`endif

endmodule
